// File: rtl/types.sv
// Shared CPU-side type definitions.
//
// cpu_mem_bus_t is the registered request bus driven towards memory:
//   ptr / ptr_valid   pointer side-channel (unused by the arbiter, held at 0)
//   addr              16-bit transaction address
//   addr_valid        request strobe, high for the whole transaction
//   write             1 = store, 0 = read
//   data2mem          16-bit store data
package types;

    typedef struct packed {
        logic [15:0] ptr;
        logic        ptr_valid;
        logic [15:0] addr;
        logic        addr_valid;
        logic        write;
        logic [15:0] data2mem;
    } cpu_mem_bus_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//
// Shares the single CPU memory port between instruction fetch (read-only)
// and load/store (read/write). One transaction is in flight at a time:
// grant, hold the bus until mem_ack, return data, or abort with err if the
// memory does not answer within TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT  cycles to wait for mem_ack before aborting (1..65535)
//   CNT_W    wait-counter width, must be able to hold TIMEOUT
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req, if_addr     fetch request, held until if_done
//   if_done, if_rdata   fetch completion pulse, registered fetch data
//   ls_req, ls_addr,
//   ls_wdata, ls_write  load/store request, held until ls_done
//   ls_done, ls_rdata   load/store completion pulse, registered load data
//   err                 pulses together with a done when the access timed out
//   mem_bus             registered request bus towards memory
//   mem_ack, mem_rdata  memory completion strobe and read data
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous requests
//                  undefined -> fixed priority, load/store beats fetch

module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [15:0]         if_addr,
    output logic                if_done,
    output logic [15:0]         if_rdata,
    input  logic                ls_req,
    input  logic [15:0]         ls_addr,
    input  logic [15:0]         ls_wdata,
    input  logic                ls_write,
    output logic                ls_done,
    output logic [15:0]         ls_rdata,
    output logic                err,
    output types::cpu_mem_bus_t mem_bus,
    input  logic                mem_ack,
    input  logic [15:0]         mem_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } state_t;

    // The counter value seen in the last allowed wait cycle; no ack there means abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    types::cpu_mem_bus_t bus_q, bus_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                if_done_q, if_done_d;
    logic                ls_done_q, ls_done_d;
    logic                err_q, err_d;
    logic [15:0]         if_rdata_q, if_rdata_d;
    logic [15:0]         ls_rdata_q, ls_rdata_d;
    logic                grant_if, grant_ls;

`ifdef MEM_ARB_RR_EN
    // 1 = load/store was granted last; reset value means fetch was last.
    logic                last_ls_q, last_ls_d;
`endif

    // Winner selection among the current requests.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (if_req && ls_req) begin
            if (last_ls_q) begin
                grant_if = 1'b1;
            end else begin
                grant_ls = 1'b1;
            end
        end else begin
            grant_if = if_req;
            grant_ls = ls_req;
        end
`else
        grant_ls = ls_req;
        grant_if = if_req && !ls_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bus_d      = bus_q;
        cnt_d      = cnt_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_ls_d  = last_ls_q;
`endif

        unique case (state_q)
            IDLE: begin
                // No grant while a done pulse is out, so a requester that is
                // still holding req in its done cycle is not immediately regranted.
                if (!if_done_q && !ls_done_q && (grant_if || grant_ls)) begin
                    bus_d.addr_valid = 1'b1;
                    cnt_d            = '0;
                    if (grant_ls) begin
                        bus_d.addr     = ls_addr;
                        bus_d.write    = ls_write;
                        bus_d.data2mem = ls_wdata;
                        state_d        = GRANT_LS;
`ifdef MEM_ARB_RR_EN
                        last_ls_d      = 1'b1;
`endif
                    end else begin
                        bus_d.addr     = if_addr;
                        bus_d.write    = 1'b0;
                        bus_d.data2mem = '0;
                        state_d        = GRANT_IF;
`ifdef MEM_ARB_RR_EN
                        last_ls_d      = 1'b0;
`endif
                    end
                end
            end

            GRANT_IF, GRANT_LS: begin
                // An ack in the final wait cycle still completes normally.
                if (mem_ack) begin
                    bus_d.addr_valid = 1'b0;
                    state_d          = IDLE;
                    if (state_q == GRANT_IF) begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end else begin
                        if (!bus_q.write) begin
                            ls_rdata_d = mem_rdata;
                        end
                        ls_done_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    bus_d.addr_valid = 1'b0;
                    state_d          = IDLE;
                    err_d            = 1'b1;
                    if (state_q == GRANT_IF) begin
                        if_done_d = 1'b1;
                    end else begin
                        ls_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d          = IDLE;
                bus_d.addr_valid = 1'b0;
            end
        endcase

        bus_d.ptr       = '0;
        bus_d.ptr_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bus_q      <= '0;
            cnt_q      <= '0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bus_q      <= bus_d;
            cnt_q      <= cnt_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_ls_q  <= last_ls_d;
`endif
        end
    end

    assign mem_bus  = bus_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

endmodule
